// File: rtl/sargantana_icache_tag_ctrl.sv
// Icache tag controller: sequences lookup, refill and flush sweeps onto the tag array.
// Optional hit/miss counters are enabled with ICACHE_TAG_STATS_EN.
module sargantana_icache_tag_ctrl #(
  parameter int ICACHE_N_WAY   = 4,
  parameter int TAG_WIDHT      = 20,
  parameter int TAG_ADDR_WIDHT = 6
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              lookup_valid_i,
  output logic                              lookup_ready_o,
  input  logic [TAG_ADDR_WIDHT-1:0]         lookup_idx_i,
  input  logic [TAG_WIDHT-1:0]              lookup_tag_i,
  output logic                              resp_valid_o,
  output logic                              resp_hit_o,
  output logic [ICACHE_N_WAY-1:0]           resp_way_o,
  output logic                              resp_multihit_o,
  input  logic                              refill_valid_i,
  output logic                              refill_ready_o,
  input  logic [ICACHE_N_WAY-1:0]           refill_way_i,
  input  logic [TAG_ADDR_WIDHT-1:0]         refill_idx_i,
  input  logic [TAG_WIDHT-1:0]              refill_tag_i,
  output logic                              refill_done_o,
  input  logic                              flush_i,
  output logic                              flush_busy_o,
  output logic [ICACHE_N_WAY-1:0]           tag_req_o,
  output logic                              tag_we_o,
  output logic                              tag_vbit_o,
  output logic                              tag_flush_o,
  output logic [TAG_WIDHT-1:0]              tag_data_o,
  output logic [TAG_ADDR_WIDHT-1:0]         tag_addr_o,
  input  logic [ICACHE_N_WAY*TAG_WIDHT-1:0] tag_way_i,
  input  logic [ICACHE_N_WAY-1:0]           vbit_i
`ifdef ICACHE_TAG_STATS_EN
  ,
  output logic [31:0]                       hit_cnt_o,
  output logic [31:0]                       miss_cnt_o
`endif
);

  localparam int PW = $clog2(ICACHE_N_WAY);
  localparam logic [ICACHE_N_WAY-1:0] ONE = ICACHE_N_WAY'(1);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e                    state_q, state_d;
  logic                      flush_pend_q;
  logic [TAG_ADDR_WIDHT-1:0] flush_cnt_q;
  logic                      s1_valid_q;
  logic [TAG_WIDHT-1:0]      s1_tag_q;
  logic [PW-1:0]             rr_q;

  logic active, in_run, sweep, restart, sweep_done;
  logic lookup_fire, refill_fire;
  logic [ICACHE_N_WAY-1:0] match, hit_oh, inv, inv_oh, rr_oh, way_d;
  logic multi_d, rr_adv;

  // Outputs are held quiet while reset is asserted.
  assign active  = ~rst_i;
  assign in_run  = (state_q == RUN);
  assign sweep   = active & ((state_q == FLUSH) | (flush_pend_q & ~s1_valid_q));
  assign restart = (state_q == FLUSH) & flush_i;
  assign sweep_done = sweep & (&flush_cnt_q) & ~restart;

  assign lookup_ready_o = active & in_run & ~flush_pend_q & ~refill_valid_i;
  assign refill_ready_o = active & in_run & ~flush_pend_q & ~s1_valid_q;
  assign lookup_fire    = lookup_valid_i & lookup_ready_o;
  assign refill_fire    = refill_valid_i & refill_ready_o;
  assign flush_busy_o   = active & (flush_pend_q | (state_q == FLUSH));
  assign tag_flush_o    = 1'b0;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Next state: sweep starts once stage1 drains, ends at last set
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:   if (sweep && !sweep_done) state_d = FLUSH;
      FLUSH: if (sweep_done) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Tag memory port: sweep, refill write or lookup read
  always_comb begin
    tag_req_o  = '0;
    tag_we_o   = 1'b0;
    tag_vbit_o = 1'b0;
    tag_data_o = '0;
    tag_addr_o = '0;
    unique case (1'b1)
      sweep: begin
        tag_req_o  = '1;
        tag_we_o   = 1'b1;
        tag_addr_o = flush_cnt_q;
      end
      refill_fire: begin
        tag_req_o  = refill_way_i;
        tag_we_o   = 1'b1;
        tag_vbit_o = 1'b1;
        tag_data_o = refill_tag_i;
        tag_addr_o = refill_idx_i;
      end
      lookup_fire: begin
        tag_req_o  = '1;
        tag_addr_o = lookup_idx_i;
      end
      default: ;
    endcase
  end

  // Pending flush request, cleared when a sweep completes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      flush_pend_q <= 1'b1;
    end else begin
      if (sweep_done) flush_pend_q <= 1'b0;
      if (flush_i)    flush_pend_q <= 1'b1;
    end
  end

  // Sweep index; a new flush during the sweep restarts it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                      flush_cnt_q <= '0;
    else if (restart | sweep_done)  flush_cnt_q <= '0;
    else if (sweep)                 flush_cnt_q <= flush_cnt_q + 1'b1;
  end

  // Stage1 holds the tag of the lookup whose read is in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_tag_q   <= '0;
    end else begin
      s1_valid_q <= lookup_fire;
      if (lookup_fire) s1_tag_q <= lookup_tag_i;
    end
  end

  // Way compare, lowest-match hit and victim selection
  always_comb begin
    match = '0;
    for (int w = 0; w < ICACHE_N_WAY; w++) begin
      match[w] = vbit_i[w] &
                 (tag_way_i[w*TAG_WIDHT +: TAG_WIDHT] == s1_tag_q);
    end
    hit_oh  = match & (~match + ONE);
    multi_d = |(match & (match - ONE));
    inv     = ~vbit_i;
    inv_oh  = inv & (~inv + ONE);
    rr_oh   = ONE << rr_q;
    way_d   = (|match) ? hit_oh : ((|inv) ? inv_oh : rr_oh);
    rr_adv  = s1_valid_q & ~(|match) & ~(|inv);
  end

  // Registered response and refill completion pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_valid_o    <= 1'b0;
      resp_hit_o      <= 1'b0;
      resp_way_o      <= '0;
      resp_multihit_o <= 1'b0;
      refill_done_o   <= 1'b0;
    end else begin
      resp_valid_o    <= s1_valid_q;
      resp_hit_o      <= s1_valid_q & (|match);
      resp_way_o      <= s1_valid_q ? way_d : '0;
      resp_multihit_o <= s1_valid_q & multi_d;
      refill_done_o   <= refill_fire;
    end
  end

  // Round-robin victim pointer, advanced only when every way is valid
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)           rr_q <= '0;
    else if (sweep_done) rr_q <= '0;
    else if (rr_adv)     rr_q <= rr_q + 1'b1;
  end

`ifdef ICACHE_TAG_STATS_EN
  // Saturating hit/miss counters, cleared when a sweep completes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (sweep_done) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (resp_valid_o) begin
      if (resp_hit_o && !(&hit_cnt_o))   hit_cnt_o  <= hit_cnt_o + 1'b1;
      if (!resp_hit_o && !(&miss_cnt_o)) miss_cnt_o <= miss_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sargantana_icache_tag_ctrl.sv
// Bench for sargantana_icache_tag_ctrl: tag memory model, reference
// cache model with response scoreboard, and directed scenarios.
module tb_sargantana_icache_tag_ctrl;

  localparam int NW = 4;
  localparam int TW = 20;
  localparam int AW = 6;
  localparam int NS = 64;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  logic          lookup_valid_i = 1'b0;
  logic          lookup_ready_o;
  logic [AW-1:0] lookup_idx_i = '0;
  logic [TW-1:0] lookup_tag_i = '0;
  logic          resp_valid_o, resp_hit_o, resp_multihit_o;
  logic [NW-1:0] resp_way_o;
  logic          refill_valid_i = 1'b0;
  logic          refill_ready_o;
  logic [NW-1:0] refill_way_i = '0;
  logic [AW-1:0] refill_idx_i = '0;
  logic [TW-1:0] refill_tag_i = '0;
  logic          refill_done_o;
  logic          flush_i = 1'b0;
  logic          flush_busy_o;
  logic [NW-1:0] tag_req_o;
  logic          tag_we_o, tag_vbit_o, tag_flush_o;
  logic [TW-1:0] tag_data_o;
  logic [AW-1:0] tag_addr_o;
  logic [NW*TW-1:0] tag_way_i;
  logic [NW-1:0] vbit_i;

  sargantana_icache_tag_ctrl #(
    .ICACHE_N_WAY(NW), .TAG_WIDHT(TW), .TAG_ADDR_WIDHT(AW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .lookup_valid_i(lookup_valid_i), .lookup_ready_o(lookup_ready_o),
    .lookup_idx_i(lookup_idx_i), .lookup_tag_i(lookup_tag_i),
    .resp_valid_o(resp_valid_o), .resp_hit_o(resp_hit_o),
    .resp_way_o(resp_way_o), .resp_multihit_o(resp_multihit_o),
    .refill_valid_i(refill_valid_i), .refill_ready_o(refill_ready_o),
    .refill_way_i(refill_way_i), .refill_idx_i(refill_idx_i),
    .refill_tag_i(refill_tag_i), .refill_done_o(refill_done_o),
    .flush_i(flush_i), .flush_busy_o(flush_busy_o),
    .tag_req_o(tag_req_o), .tag_we_o(tag_we_o), .tag_vbit_o(tag_vbit_o),
    .tag_flush_o(tag_flush_o), .tag_data_o(tag_data_o),
    .tag_addr_o(tag_addr_o), .tag_way_i(tag_way_i), .vbit_i(vbit_i)
  );

  // Tag array model: 1-cycle read latency, seeded with valid junk
  logic [TW-1:0] m_tag [NW][NS];
  logic          m_v   [NW][NS];
  logic [TW-1:0] rd_tag [NW];
  logic [NW-1:0] rd_v;
  logic          seeded = 1'b0;

  always @(posedge clk) begin
    if (!seeded) begin
      for (int w = 0; w < NW; w++) begin
        for (int s = 0; s < NS; s++) begin
          m_tag[w][s] <= 20'h12345;
          m_v[w][s]   <= 1'b1;
        end
        rd_tag[w] <= '0;
      end
      rd_v   <= '0;
      seeded <= 1'b1;
    end else begin
      for (int w = 0; w < NW; w++) begin
        if (tag_req_o[w]) begin
          if (tag_we_o) begin
            m_tag[w][tag_addr_o] <= tag_data_o;
            m_v[w][tag_addr_o]   <= tag_vbit_o;
          end else begin
            rd_tag[w] <= m_tag[w][tag_addr_o];
            rd_v[w]   <= m_v[w][tag_addr_o];
          end
        end
      end
    end
  end

  always_comb begin
    for (int w = 0; w < NW; w++) tag_way_i[w*TW +: TW] = rd_tag[w];
    vbit_i = rd_v;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference cache contents and scoreboard
  typedef struct {
    int            due;
    logic          hit;
    logic [NW-1:0] way;
    logic          multi;
  } exp_t;

  exp_t          rq[$];
  int            dq[$];
  logic          ref_v [NW][NS];
  logic [TW-1:0] ref_t [NW][NS];
  int            ref_ptr = 0;
  bit            run_chk = 1'b0;

  task automatic ref_clear();
    for (int w = 0; w < NW; w++)
      for (int s = 0; s < NS; s++) ref_v[w][s] = 1'b0;
    ref_ptr = 0;
  endtask

  function automatic exp_t model_lookup(input int idx, input logic [TW-1:0] tag);
    exp_t e;
    int   nm = 0;
    int   first = -1;
    int   inv = -1;
    e.due = 0;
    for (int w = 0; w < NW; w++) begin
      if (ref_v[w][idx] && ref_t[w][idx] == tag) begin
        nm++;
        if (first < 0) first = w;
      end
      if (!ref_v[w][idx] && inv < 0) inv = w;
    end
    e.hit   = (nm > 0);
    e.multi = (nm > 1);
    if (nm > 0) e.way = NW'(1) << first;
    else if (inv >= 0) e.way = NW'(1) << inv;
    else begin
      e.way   = NW'(1) << ref_ptr;
      ref_ptr = (ref_ptr + 1) % NW;
    end
    return e;
  endfunction

  // Compare process: response and refill-done pulses every cycle
  bit cv, cd;
  always @(negedge clk) begin
    if (run_chk && !rst_i) begin
      cv = (rq.size() > 0) && (rq[0].due == cyc);
      chk("resp_valid", resp_valid_o, cv);
      if (cv) begin
        chk("resp_fields", {resp_hit_o, resp_way_o, resp_multihit_o},
            {rq[0].hit, rq[0].way, rq[0].multi});
        void'(rq.pop_front());
      end
      cd = (dq.size() > 0) && (dq[0] == cyc);
      chk("refill_done", refill_done_o, cd);
      if (cd) void'(dq.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input int idx, input logic [TW-1:0] tag, output exp_t e);
    lookup_valid_i = 1'b1;
    lookup_idx_i   = AW'(idx);
    lookup_tag_i   = tag;
    e = model_lookup(idx, tag);
    e.due = cyc + 2;
    rq.push_back(e);
    #1;
    chk("lookup_ready", lookup_ready_o, 1);
    chk("lookup_bus", {tag_req_o, tag_we_o, tag_addr_o},
        {4'hF, 1'b0, AW'(idx)});
    step();
    lookup_valid_i = 1'b0;
  endtask

  task automatic refill(input logic [NW-1:0] mask, input int idx,
                        input logic [TW-1:0] tag);
    refill_valid_i = 1'b1;
    refill_way_i   = mask;
    refill_idx_i   = AW'(idx);
    refill_tag_i   = tag;
    #1;
    chk("refill_ready", refill_ready_o, 1);
    chk("refill_bus", {tag_req_o, tag_we_o, tag_vbit_o, tag_data_o, tag_addr_o},
        {mask, 1'b1, 1'b1, tag, AW'(idx)});
    for (int w = 0; w < NW; w++)
      if (mask[w]) begin
        ref_v[w][idx] = 1'b1;
        ref_t[w][idx] = tag;
      end
    dq.push_back(cyc + 1);
    step();
    refill_valid_i = 1'b0;
  endtask

  task automatic reset_and_sweep(input int hold);
    rst_i = 1'b1;
    rq.delete();
    dq.delete();
    ref_clear();
    repeat (hold) step();
    chk("reset_outs",
        {resp_valid_o, resp_hit_o, resp_way_o, resp_multihit_o,
         lookup_ready_o, refill_ready_o, refill_done_o, flush_busy_o,
         tag_req_o, tag_we_o, tag_vbit_o, tag_flush_o, tag_data_o, tag_addr_o},
        64'd0);
    rst_i = 1'b0;
    for (int i = 0; i < NS; i++) begin
      #1;
      chk("sweep", {flush_busy_o, tag_req_o, tag_we_o, tag_vbit_o, tag_addr_o},
          {1'b1, 4'hF, 1'b1, 1'b0, AW'(i)});
      step();
    end
    #1;
    chk("sweep_end_busy", flush_busy_o, 0);
    chk("sweep_end_ready", lookup_ready_o, 1);
    step();
  endtask

  exp_t       e;
  logic [3:0] vw [5];
  int         waited;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vw = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    repeat (3) @(posedge clk);
    #1;
    run_chk = 1'b1;
    reset_and_sweep(2);

    // Refill then hit
    refill(4'b0010, 5, 20'hABCDE);
    lookup(5, 20'hABCDE, e);
    chk("t2_model", {e.hit, e.way, e.multi}, {1'b1, 4'b0010, 1'b0});
    step();

    // Miss with ways 0 and 2 invalid picks way 0
    refill(4'b1000, 5, 20'h11111);
    lookup(5, 20'h12345, e);
    chk("t3_model", {e.hit, e.way, e.multi}, {1'b0, 4'b0001, 1'b0});
    step();

    // Full set, back-to-back round-robin victims
    refill(4'b0001, 9, 20'h90000);
    refill(4'b0010, 9, 20'h90001);
    refill(4'b0100, 9, 20'h90002);
    refill(4'b1000, 9, 20'h90003);
    for (int i = 0; i < 5; i++) begin
      lookup(9, 20'hA0000 + TW'(i), e);
      chk("t4_model", {e.hit, e.way}, {1'b0, vw[i]});
    end
    step();

    // Non-one-hot refill mask gives a multihit
    refill(4'b1010, 2, 20'h22222);
    lookup(2, 20'h22222, e);
    chk("t5_model", {e.hit, e.way, e.multi}, {1'b1, 4'b0010, 1'b1});
    step();
    step();

    // Flush while a lookup sits in stage1
    lookup(9, 20'h90002, e);
    chk("t6_model", {e.hit, e.way}, {1'b1, 4'b0100});
    flush_i        = 1'b1;
    refill_valid_i = 1'b1;
    refill_way_i   = 4'b0001;
    refill_idx_i   = AW'(7);
    refill_tag_i   = 20'h77777;
    #1;
    chk("t6_refill_held", refill_ready_o, 0);
    step();
    flush_i = 1'b0;
    ref_clear();
    #1;
    chk("t6_sweep_start", {flush_busy_o, tag_req_o, tag_we_o, tag_vbit_o, tag_addr_o},
        {1'b1, 4'hF, 1'b1, 1'b0, 6'd0});
    waited = 0;
    while (refill_ready_o !== 1'b1 && waited < 200) begin
      @(posedge clk);
      #2;
      waited++;
    end
    chk("t6_holdoff", waited, 64);
    if (refill_ready_o === 1'b1) begin
      ref_v[0][7] = 1'b1;
      ref_t[0][7] = 20'h77777;
      dq.push_back(cyc + 1);
    end
    step();
    refill_valid_i = 1'b0;
    lookup(7, 20'h77777, e);
    chk("t6_model_hit", {e.hit, e.way}, {1'b1, 4'b0001});
    lookup(9, 20'h90002, e);
    chk("t6_model_swept", {e.hit, e.way}, {1'b0, 4'b0001});
    step();
    refill(4'b1111, 9, 20'h99999);
    lookup(9, 20'h99999, e);
    chk("t6_model_multi", {e.hit, e.way, e.multi}, {1'b1, 4'b0001, 1'b1});
    lookup(9, 20'h55555, e);
    chk("t6_model_ptr0", {e.hit, e.way}, {1'b0, 4'b0001});
    step();
    step();

    // Reset with a lookup in flight: no response, fresh sweep
    lookup(5, 20'h11111, e);
    reset_and_sweep(2);
    lookup(5, 20'hABCDE, e);
    chk("t7_model", {e.hit, e.way}, {1'b0, 4'b0001});
    repeat (4) step();

    chk("sb_drain", rq.size() + dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
